// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional subtract mode (port sub) is built when SERIAL_SUB_EN is defined.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] add1,
  input  logic [WIDTH-1:0] add2,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] psum;
  logic             carry_ff;
  logic [CNTW-1:0]  cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] psum_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Shared full-adder cell and the partial sum including the bit being produced now
  assign s_bit     = a_sr[0] ^ b_sr[0] ^ carry_ff;
  assign c_next    = (a_sr[0] & b_sr[0]) | (carry_ff & (a_sr[0] ^ b_sr[0]));
  assign psum_next = {s_bit, psum};

`ifdef SERIAL_SUB_EN
  // Subtract as A + ~B + 1
  assign b_load = sub ? ~add2 : add2;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = add2;
  assign c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      psum     <= '0;
      carry_ff <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr     <= add1;
            b_sr     <= b_load;
            carry_ff <= c_load;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          psum     <= psum_next[WIDTH-1:1];
          carry_ff <= c_next;
          cnt      <= cnt + CNTW'(1);
          // MSB edge: publish the result
          if (cnt == CNTW'(WIDTH - 1)) begin
            sum   <= psum_next;
            cout  <= c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); expected results queued at start, checked at done.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] add1;
  logic [W-1:0] add2;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  logic [W:0] exp_q[$];
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .add1  (add1),
    .add2  (add2),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
    logic [W-1:0] bb;
    bb = b;
    if (s) return {1'b0, a} + {1'b0, ~bb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // One add from IDLE at a negedge; checks latency, busy span, held result, result and pulse width
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input string name);
    int lat;
    int busy_n;
    bit held_ok;
    logic [W:0] e;
    add1 = a; add2 = b; cin = c; sub = s; start = 1'b1;
    exp_q.push_back(model(a, b, c, s));
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_n = 0; held_ok = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (sum !== last_sum || cout !== last_cout) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin
        failures++;
        $display("FAIL %s_result: got cout=%b sum=%h, expected cout=%b sum=%h", name, cout, sum, e[W], e[W-1:0]);
      end
      checks++;
      if (lat != 9) begin
        failures++;
        $display("FAIL %s_latency: got %0d, expected 9", name, lat);
      end
      checks++;
      if (busy_n != 8) begin
        failures++;
        $display("FAIL %s_busy_cycles: got %0d, expected 8", name, busy_n);
      end
      checks++;
      if (!held_ok) begin
        failures++;
        $display("FAIL %s_held: sum/cout changed during RUN, expected %h/%b", name, last_sum, last_cout);
      end
      last_sum = e[W-1:0];
      last_cout = e[W];
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: got done=%b busy=%b, expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; add1 = '0; add2 = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL reset: got busy=%b done=%b sum=%h cout=%b, expected 0 0 00 0", busy, done, sum, cout);
    end
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_add(8'h5A, 8'h33, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_carry();
    run_add(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
    run_add(8'hFF, 8'hFF, 1'b1, 1'b0, "max_cin");
    run_add(8'h00, 8'h00, 1'b0, 1'b0, "zero");
    for (int i = 0; i < 3; i++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "random");
  endtask

  task automatic test_ignore_start();
    int dn;
    logic [W:0] e;
    add1 = 8'h01; add2 = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    dn = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 3) begin add1 = 8'h7F; add2 = 8'h7F; start = 1'b1; end
      if (i == 4) start = 1'b0;
      if (done) begin
        dn++;
        if (dn == 1) begin
          e = exp_q.pop_front();
          checks++;
          if ({cout, sum} !== e) begin
            failures++;
            $display("FAIL ignore_result: got cout=%b sum=%h, expected cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
          end
          last_sum = e[W-1:0]; last_cout = e[W];
        end
      end
    end
    checks++;
    if (dn != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_pulses: got %0d done pulses busy=%b, expected 1 and 0", dn, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int dn;
    add1 = 8'h55; add2 = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, expected 0 0 00 0", busy, done, sum, cout);
    end
    last_sum = '0; last_cout = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL midrun_abort: got %0d busy/done cycles after reset, expected 0", dn);
    end
    run_add(8'h10, 8'h20, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int low_n;
    int i;
    logic [W:0] e;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    na = 8'h11; nb = 8'h22;
    add1 = na; add2 = nb; cin = 1'b0; sub = 1'b0; start = 1'b1;
    exp_q.push_back(model(na, nb, 1'b0, 1'b0));
    low_n = 0; i = 0;
    while (done_at.size() < 3 && i < 60) begin
      @(negedge clk);
      i++;
      if (!busy) low_n++;
      if (done) begin
        done_at.push_back(i);
        e = exp_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
          failures++;
          $display("FAIL b2b_result: got cout=%b sum=%h, expected cout=%b sum=%h", cout, sum, e[W], e[W-1:0]);
        end
        last_sum = e[W-1:0]; last_cout = e[W];
        if (done_at.size() < 3) begin
          na = na + 8'h70; nb = nb + 8'hC3;
          add1 = na; add2 = nb;
          exp_q.push_back(model(na, nb, 1'b0, 1'b0));
        end else begin
          start = 1'b0;
        end
      end
    end
    checks++;
    if (done_at.size() != 3) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d done pulses, expected 3", done_at.size());
    end else if (done_at[0] != 9 || done_at[1] != 19 || done_at[2] != 29) begin
      failures++;
      $display("FAIL b2b_spacing: got done at %0d %0d %0d, expected 9 19 29", done_at[0], done_at[1], done_at[2]);
    end
    checks++;
    if (low_n != 5) begin
      failures++;
      $display("FAIL b2b_busy_low: got %0d low cycles, expected 5", low_n);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    run_add(8'h10, 8'h01, 1'b0, 1'b1, "sub_pos");
    run_add(8'h01, 8'h02, 1'b1, 1'b1, "sub_borrow");
    run_add(8'h3C, 8'h2A, 1'b1, 1'b0, "sub_off");
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
